// File: rtl/eth_rx_ctrl_if.sv
// Receive byte stream from the RMII receive controller to the RX FIFO.
//
// Handshake: there is no backpressure. Rx_Byte_Vld is a one-cycle strobe and
// the consumer must take Rx_Byte on every cycle the strobe is high. Rx_Sof
// qualifies the strobe of the first destination-address byte. Rx_Eof is a
// separate one-cycle pulse that never coincides with Rx_Byte_Vld. Rx_Err and
// Rx_Len are only meaningful while Rx_Eof is high.
interface eth_rx_ctrl_if;
  logic [7:0]  Rx_Byte;
  logic        Rx_Byte_Vld;
  logic        Rx_Sof;
  logic        Rx_Eof;
  logic [4:0]  Rx_Err;
  logic [10:0] Rx_Len;

  modport master (
    output Rx_Byte, Rx_Byte_Vld, Rx_Sof, Rx_Eof, Rx_Err, Rx_Len
  );

  modport slave (
    input Rx_Byte, Rx_Byte_Vld, Rx_Sof, Rx_Eof, Rx_Err, Rx_Len
  );
endinterface

// File: rtl/eth_rx_ctrl.sv
// RMII receive control: preamble/SFD hunt, LSB-first byte assembly, field
// tracking, destination filtering, CRC-32 and length checks. Emits a byte
// stream with SOF/EOF and error flags toward the RX FIFO.
module eth_rx_ctrl #(
  parameter logic [47:0] pMAC_Addr        = 48'h00_0A_35_00_00_01,
  parameter bit          pPromisc         = 1'b0,
  parameter int          pMin_Preamble    = 4,
  parameter int          pMin_Frame_Bytes = 64,
  parameter int          pMax_Frame_Bytes = 1518
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Crs_Dv,
  input  logic [1:0]   Rxd,
  output logic [3:0]   Rx_Ctrl_FSM_State,
  eth_rx_ctrl_if.master rx
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PREAMBLE  = 4'd1,
    S_SFD       = 4'd2,
    S_DEST_ADDR = 4'd3,
    S_SRC_ADDR  = 4'd4,
    S_LEN_TYPE  = 4'd5,
    S_DATA      = 4'd6,
    S_DROP      = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN     = 11'(pMin_Frame_Bytes);
  localparam logic [10:0] TOO_LONG    = 11'(pMax_Frame_Bytes + 1);
  localparam logic [7:0]  MIN_PRE     = 8'(pMin_Preamble);

  // Control state
  state_t      state_q;
  logic        armed_q;
  logic [7:0]  pre_cnt_q;
  logic [1:0]  dib_cnt_q;
  logic [5:0]  shift_q;
  logic [10:0] byte_cnt_q;
  logic [31:0] crc_q;
  logic        da_ucast_q;
  logic        da_bcast_q;
  logic        drop_addr_q;
  logic        drop_long_q;
  logic        drop_pre_q;

  // Registered outputs
  logic [7:0]  byte_q;
  logic        vld_q;
  logic        sof_q;
  logic        eof_q;
  logic [4:0]  err_q;
  logic [10:0] len_q;

  // Next-state helpers for the byte being completed this cycle
  logic [7:0]  byte_d;
  logic        byte_done_d;
  logic [10:0] cnt_d;
  logic [31:0] crc_d;
  logic        ucast_d;
  logic        bcast_d;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Station address byte by wire order; byte 0 is the most significant.
  function automatic logic [7:0] mac_byte(input logic [10:0] idx);
    case (idx)
      11'd0:   return pMAC_Addr[47:40];
      11'd1:   return pMAC_Addr[39:32];
      11'd2:   return pMAC_Addr[31:24];
      11'd3:   return pMAC_Addr[23:16];
      11'd4:   return pMAC_Addr[15:8];
      11'd5:   return pMAC_Addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Byte assembly, running CRC and address-match lookahead for this cycle
  always_comb begin
    byte_d      = {Rxd, shift_q};
    byte_done_d = (dib_cnt_q == 2'd3);
    cnt_d       = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    crc_d       = crc_byte(crc_q, byte_d);
    ucast_d     = da_ucast_q & (byte_d == mac_byte(byte_cnt_q));
    bcast_d     = da_bcast_q & (byte_d == 8'hFF);
  end

  // Receive FSM with registered stream outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      pre_cnt_q   <= 8'd0;
      dib_cnt_q   <= 2'd0;
      shift_q     <= 6'd0;
      byte_cnt_q  <= 11'd0;
      crc_q       <= 32'hFFFF_FFFF;
      da_ucast_q  <= 1'b0;
      da_bcast_q  <= 1'b0;
      drop_addr_q <= 1'b0;
      drop_long_q <= 1'b0;
      drop_pre_q  <= 1'b0;
      byte_q      <= 8'd0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 5'd0;
      len_q       <= 11'd0;
    end else begin
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      // A frame already on the wire at reset release must be skipped.
      if (!Crs_Dv) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (Crs_Dv && armed_q && (Rxd == 2'b01)) begin
            state_q   <= S_PREAMBLE;
            pre_cnt_q <= 8'd1;
          end
        end

        S_PREAMBLE: begin
          if (!Crs_Dv) begin
            state_q <= S_IDLE;
          end else if (Rxd == 2'b01) begin
            if (pre_cnt_q != 8'hFF) pre_cnt_q <= pre_cnt_q + 8'd1;
          end else if ((Rxd == 2'b11) && (pre_cnt_q >= MIN_PRE)) begin
            state_q     <= S_SFD;
            dib_cnt_q   <= 2'd0;
            byte_cnt_q  <= 11'd0;
            crc_q       <= 32'hFFFF_FFFF;
            da_ucast_q  <= 1'b1;
            da_bcast_q  <= 1'b1;
            drop_addr_q <= 1'b0;
            drop_long_q <= 1'b0;
            drop_pre_q  <= 1'b0;
          end else begin
            state_q    <= S_DROP;
            drop_pre_q <= 1'b1;
          end
        end

        // The cycle after the SFD dibit already carries dibit 0 of the frame.
        S_SFD: begin
          if (!Crs_Dv) begin
            state_q <= S_IDLE;
          end else begin
            shift_q[1:0] <= Rxd;
            dib_cnt_q    <= 2'd1;
            state_q      <= S_DEST_ADDR;
          end
        end

        S_DEST_ADDR, S_SRC_ADDR, S_LEN_TYPE, S_DATA: begin
          if (!Crs_Dv) begin
            state_q <= S_DONE;
          end else if (!byte_done_d) begin
            case (dib_cnt_q)
              2'd0:    shift_q[1:0] <= Rxd;
              2'd1:    shift_q[3:2] <= Rxd;
              default: shift_q[5:4] <= Rxd;
            endcase
            dib_cnt_q <= dib_cnt_q + 2'd1;
          end else begin
            dib_cnt_q  <= 2'd0;
            byte_cnt_q <= cnt_d;
            if (cnt_d == TOO_LONG) begin
              // Oversized: the excess byte is swallowed.
              state_q     <= S_DROP;
              drop_long_q <= 1'b1;
            end else begin
              crc_q  <= crc_d;
              byte_q <= byte_d;
              vld_q  <= 1'b1;
              sof_q  <= (byte_cnt_q == 11'd0);
              case (state_q)
                S_DEST_ADDR: begin
                  da_ucast_q <= ucast_d;
                  da_bcast_q <= bcast_d;
                  if (cnt_d == 11'd6) begin
                    if (ucast_d || bcast_d || pPromisc) begin
                      state_q <= S_SRC_ADDR;
                    end else begin
                      state_q     <= S_DROP;
                      drop_addr_q <= 1'b1;
                    end
                  end
                end
                S_SRC_ADDR: if (cnt_d == 11'd12) state_q <= S_LEN_TYPE;
                S_LEN_TYPE: if (cnt_d == 11'd14) state_q <= S_DATA;
                default: ;
              endcase
            end
          end
        end

        // Preamble-level drops vanish silently; field-level drops report.
        S_DROP: begin
          if (!Crs_Dv) state_q <= drop_pre_q ? S_IDLE : S_DONE;
        end

        S_DONE: begin
          eof_q <= 1'b1;
          len_q <= byte_cnt_q;
          if (drop_addr_q || drop_long_q) begin
            err_q <= {drop_addr_q, drop_long_q, 3'b000};
          end else begin
            err_q <= {2'b00, (byte_cnt_q < MIN_LEN), (dib_cnt_q != 2'd0),
                      (crc_q != CRC_RESIDUE)};
          end
          dib_cnt_q <= 2'd0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Rx_Ctrl_FSM_State = state_q;
  assign rx.Rx_Byte        = byte_q;
  assign rx.Rx_Byte_Vld    = vld_q;
  assign rx.Rx_Sof         = sof_q;
  assign rx.Rx_Eof         = eof_q;
  assign rx.Rx_Err         = err_q;
  assign rx.Rx_Len         = len_q;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Bench for eth_rx_ctrl: one non-promiscuous and one promiscuous instance
// share the RMII inputs; frames are built with a bit-serial CRC reference
// and the expected byte stream / flags come from the frame rules.
module tb_eth_rx_ctrl;

  localparam logic [47:0] MAC   = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
  localparam int          MINB  = 64;
  localparam int          MAXB  = 1518;

  // Clock / reset
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Crs_Dv = 1'b0;
  logic [1:0] Rxd = 2'b00;
  logic [3:0] st0, st1;

  always #10 Clk = ~Clk;

  eth_rx_ctrl_if rx0();
  eth_rx_ctrl_if rx1();

  eth_rx_ctrl #(.pPromisc(1'b0)) u_dut (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(Crs_Dv), .Rxd(Rxd),
    .Rx_Ctrl_FSM_State(st0), .rx(rx0.master)
  );

  eth_rx_ctrl #(.pPromisc(1'b1)) u_prm (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(Crs_Dv), .Rxd(Rxd),
    .Rx_Ctrl_FSM_State(st1), .rx(rx1.master)
  );

  // Scoreboard state
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got0_q[$], got1_q[$];
  int sof0_n, sof0_pos, eof0_n, both0_n;
  int sof1_n, sof1_pos, eof1_n, both1_n;
  logic [4:0]  err0, err1;
  logic [10:0] len0, len1;
  int m0_b, m0_s, m0_e, m1_b, m1_s, m1_e;
  int n_vec = 0;
  int n_err = 0;
  string cur = "reset";

  // Output monitors, sampled on the falling edge
  always @(negedge Clk) begin
    if (rx0.Rx_Byte_Vld) begin
      if (rx0.Rx_Sof) begin sof0_n++; sof0_pos = got0_q.size(); end
      got0_q.push_back(rx0.Rx_Byte);
    end
    if (rx0.Rx_Eof) begin
      eof0_n++; err0 = rx0.Rx_Err; len0 = rx0.Rx_Len;
      if (rx0.Rx_Byte_Vld) both0_n++;
    end
    if (rx1.Rx_Byte_Vld) begin
      if (rx1.Rx_Sof) begin sof1_n++; sof1_pos = got1_q.size(); end
      got1_q.push_back(rx1.Rx_Byte);
    end
    if (rx1.Rx_Eof) begin
      eof1_n++; err1 = rx1.Rx_Err; len1 = rx1.Rx_Len;
      if (rx1.Rx_Byte_Vld) both1_n++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic c, input logic [1:0] d);
    Crs_Dv = c;
    Rxd    = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  task automatic send_pre(input int n01);
    repeat (n01) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  task automatic send_bytes(input int lo, input int hi);
    logic [7:0] b;
    for (int i = lo; i <= hi; i++) begin
      b = tx_q[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
  endtask

  task automatic send_frame(input int n01, input int extra);
    send_pre(n01);
    send_bytes(0, tx_q.size() - 1);
    repeat (extra) drive(1'b1, 2'($urandom_range(0, 3)));
    idle(12);
  endtask

  // Reference FCS: bit-serial over the frame, complemented.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ tx_q[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] da, input int plen, input bit flip);
    logic [31:0] f;
    tx_q.delete();
    for (int i = 5; i >= 0; i--) tx_q.push_back(da[8*i +: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
    tx_q.push_back(8'(plen >> 8));
    tx_q.push_back(8'(plen));
    for (int i = 0; i < plen; i++) tx_q.push_back(8'($urandom));
    f = fcs_of(tx_q.size());
    for (int i = 0; i < 4; i++) tx_q.push_back(f[8*i +: 8]);
    if (flip) tx_q[20] = tx_q[20] ^ 8'h01;
  endtask

  task automatic take_marks;
    m0_b = got0_q.size(); m0_s = sof0_n; m0_e = eof0_n;
    m1_b = got1_q.size(); m1_s = sof1_n; m1_e = eof1_n;
  endtask

  task automatic check_rx(input int dut, input bit exp_eof, input logic [4:0] mask,
                          input logic [4:0] exp_err, input bit chk_len,
                          input logic [10:0] exp_len);
    int nb, ns, ne, mb, sp, bo;
    logic [4:0]  er;
    logic [10:0] ln;
    logic [7:0]  b;
    if (dut == 0) begin
      mb = m0_b; nb = got0_q.size() - m0_b; ns = sof0_n - m0_s; ne = eof0_n - m0_e;
      sp = sof0_pos; er = err0; ln = len0; bo = both0_n;
    end else begin
      mb = m1_b; nb = got1_q.size() - m1_b; ns = sof1_n - m1_s; ne = eof1_n - m1_e;
      sp = sof1_pos; er = err1; ln = len1; bo = both1_n;
    end
    chk($sformatf("d%0d nbytes", dut), nb, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nb; i++) begin
      b = (dut == 0) ? got0_q[mb + i] : got1_q[mb + i];
      chk($sformatf("d%0d byte%0d", dut, i), b, exp_q[i]);
    end
    chk($sformatf("d%0d sof_cnt", dut), ns, (exp_q.size() > 0) ? 1 : 0);
    if (exp_q.size() > 0 && ns > 0) chk($sformatf("d%0d sof_pos", dut), sp, mb);
    chk($sformatf("d%0d eof_cnt", dut), ne, exp_eof ? 1 : 0);
    if (exp_eof && ne > 0) begin
      chk($sformatf("d%0d err", dut), er & mask, exp_err);
      if (chk_len) chk($sformatf("d%0d len", dut), ln, exp_len);
    end
    chk($sformatf("d%0d eof_vld_overlap", dut), bo, 0);
  endtask

  // Reference model: which bytes come out and which flags accompany Eof.
  task automatic expect_and_check(input int dut, input bit promisc, input bit bad,
                                  input int extra);
    int n;
    logic [47:0] da;
    bit hit;
    logic [4:0] m, e;
    n  = tx_q.size();
    da = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]};
    hit = (da == MAC) || (da == BCAST) || promisc;
    exp_q.delete();
    if (!hit) begin
      for (int i = 0; i < 6; i++) exp_q.push_back(tx_q[i]);
      m = 5'b10000; e = 5'b10000;
    end else if (n > MAXB) begin
      for (int i = 0; i < MAXB; i++) exp_q.push_back(tx_q[i]);
      m = 5'b01000; e = 5'b01000;
    end else begin
      exp_q = tx_q;
      m = 5'b11111;
      e = {2'b00, (n < MINB), ((extra % 4) != 0), bad};
    end
    check_rx(dut, 1'b1, m, e, hit && (n <= MAXB), 11'(n));
  endtask

  task automatic frame_both(input string name, input logic [47:0] da, input int plen,
                            input bit bad, input int n01, input int extra);
    cur = name;
    build(da, plen, bad);
    take_marks();
    send_frame(n01, extra);
    expect_and_check(0, 1'b0, bad, extra);
    expect_and_check(1, 1'b1, bad, extra);
  endtask

  task automatic check_outputs_zero;
    chk("state0", st0, 4'd0);
    chk("state1", st1, 4'd0);
    chk("vld", rx0.Rx_Byte_Vld, 1'b0);
    chk("sof", rx0.Rx_Sof, 1'b0);
    chk("eof", rx0.Rx_Eof, 1'b0);
    chk("err", rx0.Rx_Err, 5'd0);
    chk("len", rx0.Rx_Len, 11'd0);
    chk("byte", rx0.Rx_Byte, 8'd0);
    chk("vld1", rx1.Rx_Byte_Vld, 1'b0);
  endtask

  // Directed sequence followed by randomized frames
  initial begin
    logic [47:0] da;
    int sel;
    Rst = 1'b0; Crs_Dv = 1'b0; Rxd = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    cur = "reset";
    check_outputs_zero();
    Rst = 1'b1;
    idle(4);

    frame_both("good",      MAC,   46, 1'b0, 31, 0);
    frame_both("crc_flip",  MAC,   46, 1'b1, 31, 0);
    frame_both("align",     MAC,   46, 1'b0, 31, 2);
    frame_both("runt_bc",   BCAST, 22, 1'b0, 31, 0);
    frame_both("addr_drop", OTHER, 46, 1'b0, 31, 0);

    // Preamble one dibit short of the minimum: silently discarded
    cur = "pre_short";
    build(MAC, 46, 1'b0);
    take_marks();
    send_frame(3, 0);
    exp_q.delete();
    check_rx(0, 1'b0, 5'd0, 5'd0, 1'b0, 11'd0);
    check_rx(1, 1'b0, 5'd0, 5'd0, 1'b0, 11'd0);

    frame_both("pre_min", MAC, 46, 1'b0, 4, 0);

    // Reset in the middle of byte 20 with carrier held high
    cur = "rst_mid";
    build(MAC, 46, 1'b0);
    send_pre(31);
    send_bytes(0, 19);
    Rst = 1'b0;
    #1;
    take_marks();
    check_outputs_zero();
    send_bytes(20, 21);
    Rst = 1'b1;
    send_bytes(22, tx_q.size() - 1);
    idle(12);
    exp_q.delete();
    check_rx(0, 1'b0, 5'd0, 5'd0, 1'b0, 11'd0);
    check_rx(1, 1'b0, 5'd0, 5'd0, 1'b0, 11'd0);

    frame_both("after_rst", MAC, 46, 1'b0, 31, 0);

    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 2);
      da  = (sel == 0) ? MAC : (sel == 1) ? BCAST : OTHER;
      frame_both($sformatf("rand%0d", r), da, $urandom_range(20, 80),
                 1'($urandom_range(0, 1)), 31, $urandom_range(0, 3));
    end

    frame_both("too_long", MAC, 1502, 1'b0, 31, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_ctrl.md
Name: eth_rx_ctrl

Overview:
RMII receive control for the simpleEthernet MAC, the receive-side counterpart of the transmit control path. It samples RMII dibits at 50 MHz (100 Mbps, one dibit per Clk), hunts preamble/SFD and assembles bytes LSB-first. It walks DEST_ADDR/SRC_ADDR/LEN_TYPE/DATA field states, filters on destination address, checks CRC-32 and length, and presents a byte stream with SOF/EOF/error flags to the downstream RX FIFO.

Parameters:
pMAC_Addr, 48'h00_0A_35_00_00_01, station address; byte 0 on the wire is bits [47:40].
pPromisc, 0, 1 = accept any destination address.
pMin_Preamble, 4, minimum consecutive 01 dibits required before the SFD dibit 11.
pMin_Frame_Bytes, 64, minimum bytes from DEST_ADDR through FCS.
pMax_Frame_Bytes, 1518, maximum bytes from DEST_ADDR through FCS.

Ports:
Clk  in  1  50 MHz RMII reference clock.
Rst  in  1  asynchronous, active-low reset (0 = reset).
Crs_Dv  in  1  RMII carrier sense/data valid.
Rxd  in  2  RMII receive dibit.
Rx_Ctrl_FSM_State  out  4  current state encoding.
Rx_Byte  out  8  received byte.
Rx_Byte_Vld  out  1  one-cycle strobe; Rx_Byte is valid.
Rx_Sof  out  1  high with the Rx_Byte_Vld of the first DEST_ADDR byte.
Rx_Eof  out  1  one-cycle end-of-frame pulse.
Rx_Err  out  5  error flags, valid with Rx_Eof: [0] CRC, [1] alignment, [2] runt, [3] too long, [4] address drop.
Rx_Len  out  11  byte count DEST_ADDR..FCS, valid with Rx_Eof; saturates at 2047.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0, state IDLE, counters/CRC cleared, Armed=0.
- Armed flag: set when Crs_Dv is sampled 0. IDLE starts a frame only when Armed=1, so a frame already in progress at reset release is ignored.
- State encoding: IDLE=0, PREAMBLE=1, SFD=2, DEST_ADDR=3, SRC_ADDR=4, LEN_TYPE=5, DATA=6, DROP=7, DONE=8. SFD is transient: one cycle after SFD detection, then DEST_ADDR.
- IDLE:
  - Crs_Dv=1, Armed, Rxd=01 -> PREAMBLE, preamble count=1.
  - Rxd=00 with Crs_Dv=1 -> stay in IDLE.
- PREAMBLE:
  - Crs_Dv=0 -> IDLE, no Eof.
  - Rxd=01 -> count+1, saturating.
  - Rxd=11 with count>=pMin_Preamble -> SFD.
  - Rxd=11 with count too short, or Rxd=00/10 -> DROP. Frame is silently discarded: no Sof, Eof, or error.
- Byte assembly: dibit k (0..3) loads bits [2k+1:2k]. Rx_Byte/Rx_Byte_Vld are registered the cycle after the 4th dibit is sampled.
- Field states, counted in bytes:
  - DEST_ADDR: 6 bytes, compared against pMAC_Addr and FF:FF:FF:FF:FF:FF.
  - SRC_ADDR: 6 bytes.
  - LEN_TYPE: 2 bytes.
  - DATA: remaining bytes including the 4 FCS bytes; FCS is not split out.
  - All field bytes are forwarded.
- Address filter: evaluated after the 6th DEST_ADDR byte.
  - No match and pPromisc=0 -> DROP with Rx_Err[4] pending.
  - The 6 DEST bytes have already been emitted; downstream discards them on the Err.
- DROP: no Rx_Byte_Vld. On Crs_Dv=0 -> DONE, except a DROP entered from PREAMBLE/SFD, which returns to IDLE.
- Too long: byte count reaching pMax_Frame_Bytes+1 -> Rx_Err[3], DROP. The excess byte is not emitted.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per completed byte from DEST_ADDR onward, including FCS bytes.
  - Good frame leaves residue 0xDEBB20E3; any other value sets Rx_Err[0].
- End of frame: Crs_Dv sampled 0 in DEST_ADDR..DATA -> DONE.
  - In DONE: one-cycle pulse of Rx_Eof with Rx_Err and Rx_Len, then IDLE.
  - Rx_Err[1]: partial byte pending (1..3 dibits); the partial byte is discarded, not emitted.
  - Rx_Err[2]: Rx_Len < pMin_Frame_Bytes.
  - If the last byte completes on the same cycle Crs_Dv falls, that byte is still emitted and included in CRC; Eof follows the byte strobe by at least 1 cycle.
- Crs_Dv toggling inside a frame is not supported: the first 0 sample ends the frame.
- Rx_Eof and Rx_Byte_Vld never assert in the same cycle.
- Reset mid-frame: outputs clear immediately, no Eof. Re-arm requires Crs_Dv=0.

Test Plan:
- Good frame: 7x0x55, 0xD5, dest=pMAC_Addr, 46-byte payload, correct FCS -> 64 Rx_Byte_Vld, Sof on first, Eof with Rx_Err=0, Rx_Len=64.
- Same frame with one payload bit flipped -> all 64 bytes emitted, Eof with Rx_Err=5'b00001.
- Good frame plus 2 extra dibits before Crs_Dv falls -> Rx_Err[1]=1, Rx_Len=64, no 65th byte.
- 40-byte broadcast frame (dest FF:..:FF) with valid FCS -> Rx_Err=5'b00100, Rx_Len=40.
- Dest 02:00:00:00:00:99, pPromisc=0 -> exactly 6 bytes emitted, Eof with Rx_Err[4]=1; with pPromisc=1 -> 64 bytes, Rx_Err=0.
- Rst=0 during byte 20 with Crs_Dv held high, released mid-frame -> outputs 0, no Eof, no bytes until Crs_Dv low; the next good frame is received normally.
